// File: rtl/spi_slave_obi_seq.sv
// SPI word streams to a single-outstanding OBI master with wrap bursts and one-word read prefetch; one OBI access per word.
// obi_req is held until obi_gnt, and SPI streams stall via wr_data_ready/rd_data_valid. `define SPI_OBI_SEQ_ERR_EN adds obi_err/bus_err.
module spi_slave_obi_seq (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_addr_valid,
  input  logic        cmd_rd_wr,
  input  logic [15:0] wrap_length,
  input  logic [31:0] wr_data,
  input  logic        wr_data_valid,
  output logic        wr_data_ready,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  input  logic        rd_data_ready,
  output logic        obi_req,
  input  logic        obi_gnt,
  output logic [31:0] obi_addr,
  output logic        obi_we,
  output logic [3:0]  obi_be,
  output logic [31:0] obi_wdata,
  input  logic        obi_rvalid,
  input  logic [31:0] obi_rdata
`ifdef SPI_OBI_SEQ_ERR_EN
  ,
  input  logic        obi_err,
  output logic        bus_err
`endif
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, RD_HOLD, WR_DATA, WR_REQ, WR_RSP} state_t;
  state_t state, state_nxt;

  logic [31:0] base, cur, pend_addr, sel_addr, rdata_eff;
  logic [15:0] word_cnt, wrap_len, pend_wrap, sel_wrap, cnt_inc;
  logic        pend, pend_rw, sel_rw;
  logic        busy, rsp_done, start, rd_capture, pop, advance, wr_take;

  // A command arriving mid-access waits in pend; the freshest command wins when the response lands.
  always_comb begin
    busy       = (state == RD_REQ) || (state == RD_RSP) || (state == WR_REQ) || (state == WR_RSP);
    rsp_done   = obi_rvalid && ((state == RD_RSP) || (state == WR_RSP));
    sel_rw     = cmd_addr_valid ? cmd_rd_wr   : pend_rw;
    sel_addr   = cmd_addr_valid ? cmd_addr    : pend_addr;
    sel_wrap   = cmd_addr_valid ? wrap_length : pend_wrap;
    start      = (cmd_addr_valid && !busy) || (rsp_done && (pend || cmd_addr_valid));
    rd_capture = rsp_done && (state == RD_RSP) && !start;
    pop        = (state == RD_HOLD) && rd_data_valid && rd_data_ready && !start;
    advance    = pop || ((state == WR_RSP) && obi_rvalid && !start);
    wr_take    = (state == WR_DATA) && wr_data_valid && !start;
    cnt_inc    = word_cnt + 16'd1;
`ifdef SPI_OBI_SEQ_ERR_EN
    rdata_eff  = obi_err ? 32'hBADACCE5 : obi_rdata;
`else
    rdata_eff  = obi_rdata;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = sel_rw ? RD_REQ : WR_DATA;
    end else begin
      case (state)
        RD_REQ:  if (obi_gnt)    state_nxt = RD_RSP;
        RD_RSP:  if (obi_rvalid) state_nxt = RD_HOLD;
        RD_HOLD: if (pop)        state_nxt = RD_REQ;
        WR_DATA: if (wr_take)    state_nxt = WR_REQ;
        WR_REQ:  if (obi_gnt)    state_nxt = WR_RSP;
        WR_RSP:  if (obi_rvalid) state_nxt = WR_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    obi_req       = (state == RD_REQ) || (state == WR_REQ);
    obi_we        = (state == WR_REQ);
    obi_be        = 4'hF;
    obi_addr      = cur;
    wr_data_ready = (state == WR_DATA);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      base          <= '0;
      cur           <= '0;
      word_cnt      <= '0;
      wrap_len      <= '0;
      pend          <= 1'b0;
      pend_rw       <= 1'b0;
      pend_addr     <= '0;
      pend_wrap     <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      obi_wdata     <= '0;
    end else begin
      if (start) begin
        pend <= 1'b0;
      end else if (cmd_addr_valid && busy) begin
        pend      <= 1'b1;
        pend_addr <= cmd_addr;
        pend_rw   <= cmd_rd_wr;
        pend_wrap <= wrap_length;
      end

      if (start) begin
        base          <= sel_addr;
        cur           <= sel_addr;
        word_cnt      <= '0;
        wrap_len      <= sel_wrap;
        rd_data_valid <= 1'b0;
      end else if (advance) begin
        if ((wrap_len != 16'd0) && (cnt_inc == wrap_len)) begin
          cur      <= base;
          word_cnt <= '0;
        end else begin
          cur      <= cur + 32'd4;
          word_cnt <= cnt_inc;
        end
      end

      if (rd_capture) begin
        rd_data       <= rdata_eff;
        rd_data_valid <= 1'b1;
      end else if (pop) begin
        rd_data_valid <= 1'b0;
      end

      if (wr_take) obi_wdata <= wr_data;
    end
  end

`ifdef SPI_OBI_SEQ_ERR_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                  bus_err <= 1'b0;
    else if (rsp_done && obi_err) bus_err <= 1'b1;
    else if (cmd_addr_valid)      bus_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_slave_obi_seq.sv
// Scoreboard bench: random OBI slave timing, expected OBI accesses and SPI read words come from an address/memory model.
module tb_spi_slave_obi_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] cmd_addr;
  logic        cmd_addr_valid, cmd_rd_wr;
  logic [15:0] wrap_length;
  logic [31:0] wr_data;
  logic        wr_data_valid, wr_data_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid, rd_data_ready;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;
`ifdef SPI_OBI_SEQ_ERR_EN
  logic        obi_err, bus_err;
`endif

  always #5 sys_clk = ~sys_clk;

  spi_slave_obi_seq dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_addr(cmd_addr), .cmd_addr_valid(cmd_addr_valid), .cmd_rd_wr(cmd_rd_wr), .wrap_length(wrap_length),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we), .obi_be(obi_be),
    .obi_wdata(obi_wdata), .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata)
`ifdef SPI_OBI_SEQ_ERR_EN
    , .obi_err(obi_err), .bus_err(bus_err)
`endif
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } obi_t;
  obi_t        exp_obi[$];
  logic [31:0] exp_rd[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  int checks = 0, errors = 0;
  int gnt_fix = -1, lat_fix = -1, gmax = 2, lmax = 2;
  bit gnt_block = 0, err_next = 0;
  int grants = 0, rsps = 0, mark = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] addr_at(input logic [31:0] b, input int wrap, input int i);
    return b + 32'(4 * ((wrap == 0) ? i : (i % wrap)));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic bit cond(input int k);
    case (k)
      0: return wr_data_ready;
      1: return rd_data_valid;
      2: return obi_req && obi_we;
      3: return (exp_obi.size() == 0) && wr_data_ready;
      4: return grants > mark;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int k, input string name);
    int n = 0;
    while (!cond(k) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (!cond(k)) begin
      errors++;
      $display("FAIL timeout_%s actual=not_seen_after_%0d_cycles required=seen", name, n);
    end
  endtask

  // OBI slave: random grant stall and response latency; checks every granted access against the scoreboard.
  initial begin : slave
    bit pend = 0, seen = 0, unstable = 0, rdy_bad = 0, first = 0, rsp_err = 0;
    int stall = 0, gdel = 0, wait_c = 0;
    logic [31:0] s_addr, s_wdata, rsp_data;
    logic s_we;
    obi_t e;
    obi_gnt = 0; obi_rvalid = 0; obi_rdata = '0;
`ifdef SPI_OBI_SEQ_ERR_EN
    obi_err = 0;
`endif
    forever begin
      tick();
      obi_gnt = 0;
      obi_rvalid = 0;
`ifdef SPI_OBI_SEQ_ERR_EN
      obi_err = 0;
`endif
      if (pend) begin
        if (first) begin
          check("req_drop_after_gnt", obi_req, 0);
          first = 0;
        end
        if (wait_c == 0) begin
          obi_rvalid = 1;
          obi_rdata  = rsp_data;
`ifdef SPI_OBI_SEQ_ERR_EN
          obi_err    = rsp_err;
`endif
          pend = 0;
          rsps++;
        end else begin
          wait_c--;
        end
      end else if (obi_req) begin
        if (!seen) begin
          seen = 1; s_addr = obi_addr; s_we = obi_we; s_wdata = obi_wdata;
          unstable = 0; rdy_bad = 0; stall = 0;
          gdel = (gnt_fix >= 0) ? gnt_fix : $urandom_range(0, gmax);
        end else if (obi_addr !== s_addr || obi_we !== s_we || obi_wdata !== s_wdata) begin
          unstable = 1;
        end
        if (wr_data_ready) rdy_bad = 1;
        if (!gnt_block && stall >= gdel) begin
          obi_gnt = 1; grants++; seen = 0; pend = 1; first = 1;
          wait_c = (lat_fix >= 0) ? lat_fix : $urandom_range(0, lmax);
          check("obi_stable_while_stalled", unstable, 0);
          check("wr_ready_low_during_req", rdy_bad, 0);
          check("obi_be", obi_be, 4'hF);
          if (exp_obi.size() == 0) begin
            checks++; errors++;
            $display("FAIL obi_unexpected actual=addr_%h_we_%0b required=no_access", obi_addr, obi_we);
          end else begin
            e = exp_obi.pop_front();
            check("obi_addr", obi_addr, e.addr);
            check("obi_we", obi_we, e.we);
            if (e.we) check("obi_wdata", obi_wdata, e.wdata);
          end
          if (obi_we) begin
            slave_mem[obi_addr] = obi_wdata;
            rsp_data = '0;
          end else begin
            rsp_data = slave_mem.exists(obi_addr) ? slave_mem[obi_addr] : init_word(obi_addr);
          end
          rsp_err = err_next;
          err_next = 0;
        end else begin
          stall++;
        end
      end else begin
        seen = 0;
      end
    end
  end

  initial begin : rd_mon
    forever begin
      @(negedge sys_clk);
      if (rd_data_valid && rd_data_ready) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=%h required=no_word", rd_data);
        end else begin
          check("rd_data", rd_data, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic pulse_cmd(input logic [31:0] a, input logic rw, input int wrap);
    cmd_addr = a; cmd_rd_wr = rw; wrap_length = 16'(wrap); cmd_addr_valid = 1;
    tick();
    cmd_addr_valid = 0;
  endtask

  task automatic write_words(input logic [31:0] b, input int wrap, input int n, input logic [31:0] pat);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = (pat != 0) ? pat + 32'(i) : $urandom();
      exp_obi.push_back('{addr_at(b, wrap, i), 1'b1, w});
      model_mem[addr_at(b, wrap, i)] = w;
      wait_until(0, "wr_ready");
      repeat ($urandom_range(0, 1)) tick();
      wr_data = w; wr_data_valid = 1;
      tick();
      wr_data_valid = 0;
    end
    wait_until(3, "wr_done");
  endtask

  task automatic write_session(input logic [31:0] b, input int wrap, input int n, input logic [31:0] pat);
    pulse_cmd(b, 1'b0, wrap);
    write_words(b, wrap, n, pat);
  endtask

  // Pops n words; the prefetch of word n is expected on OBI but never popped.
  task automatic read_session(input logic [31:0] b, input int wrap, input int n, input bit err_first);
    for (int i = 0; i <= n; i++) begin
      exp_obi.push_back('{addr_at(b, wrap, i), 1'b0, 32'h0});
      if (i < n) exp_rd.push_back((err_first && i == 0) ? 32'hBADACCE5 : model_rd(addr_at(b, wrap, i)));
    end
    err_next = err_first;
    pulse_cmd(b, 1'b1, wrap);
    check("req_rise_after_cmd", obi_req, 1);
    check("first_req_addr", obi_addr, b);
    for (int i = 0; i < n; i++) begin
      wait_until(1, "rd_valid");
      repeat ($urandom_range(0, 2)) tick();
      rd_data_ready = 1;
      tick();
      rd_data_ready = 0;
    end
    wait_until(1, "prefetch");
    check("obi_queue_drained", exp_obi.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] b;
    int w, n, r0;
    bit bad;
    sys_rst = 1; cmd_addr = '0; cmd_addr_valid = 0; cmd_rd_wr = 0; wrap_length = '0;
    wr_data = '0; wr_data_valid = 0; rd_data_ready = 0;
    repeat (3) tick();
    check("rst_obi_req", obi_req, 0);
    check("rst_obi_we", obi_we, 0);
    check("rst_obi_addr", obi_addr, 0);
    check("rst_obi_wdata", obi_wdata, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_data_valid, 0);
    check("rst_wr_ready", wr_data_ready, 0);
`ifdef SPI_OBI_SEQ_ERR_EN
    check("rst_bus_err", bus_err, 0);
`endif
    sys_rst = 0;
    tick();

    gnt_fix = 0; lat_fix = 1;
    read_session(32'h1000_0000, 0, 1, 0);
    gnt_fix = 4; lat_fix = -1;
    write_session(32'h2000_0000, 0, 3, 32'hA5A5_0001);
    gnt_fix = -1;
    read_session(32'h0000_0030, 4, 6, 0);
    read_session(32'h2000_0000, 0, 3, 0);

    // Abort: write command lands while the read response is outstanding.
    exp_obi.push_back('{32'h0000_5000, 1'b0, 32'h0});
    gnt_fix = 0; lat_fix = 6; mark = grants;
    pulse_cmd(32'h0000_5000, 1'b1, 0);
    wait_until(4, "abort_gnt");
    tick();
    r0 = rsps;
    pulse_cmd(32'h0000_0040, 1'b0, 0);
    check("abort_rsp_outstanding", rsps, r0);
    bad = 0; n = 0;
    while (!wr_data_ready && n < 50) begin
      if (rd_data_valid) bad = 1;
      tick();
      n++;
    end
    check("abort_no_rd_valid", bad, 0);
    check("abort_wr_after_rsp", rsps, r0 + 1);
    check("abort_wr_ready", wr_data_ready, 1);
    gnt_fix = -1; lat_fix = -1;
    write_words(32'h0000_0040, 0, 1, 32'hDEAD_0040);

    for (int s = 0; s < 16; s++) begin
      b = $urandom() & 32'hFFFF_FFFC;
      if (s % 5 == 4) b = 32'hFFFF_FFF0;
      w = $urandom_range(0, 5);
      n = $urandom_range(1, 6);
      gmax = $urandom_range(0, 3);
      lmax = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        write_session(b, w, n, 32'h0);
        read_session(b, w, n, 0);
      end else begin
        read_session(b, w, n, 0);
      end
    end

`ifdef SPI_OBI_SEQ_ERR_EN
    read_session(32'h0000_7000, 0, 1, 1);
    check("bus_err_set", bus_err, 1);
    pulse_cmd(32'h0000_7100, 1'b0, 0);
    check("bus_err_clear", bus_err, 0);
`endif

    // Reset while a write request is stalled on the bus.
    gnt_block = 1;
    pulse_cmd(32'h0000_6000, 1'b0, 0);
    wait_until(0, "rst_wr_ready");
    wr_data = 32'h1234_5678; wr_data_valid = 1;
    tick();
    wr_data_valid = 0;
    wait_until(2, "rst_wr_req");
    repeat (2) tick();
    check("stalled_req_held", obi_req, 1);
    sys_rst = 1;
    tick();
    check("mid_rst_obi_req", obi_req, 0);
    check("mid_rst_obi_we", obi_we, 0);
    check("mid_rst_obi_addr", obi_addr, 0);
    check("mid_rst_obi_wdata", obi_wdata, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_rd_valid", rd_data_valid, 0);
    check("mid_rst_wr_ready", wr_data_ready, 0);
    sys_rst = 0; gnt_block = 0;
    repeat (3) tick();
    check("post_rst_idle_req", obi_req, 0);
    read_session(32'h2000_0000, 0, 2, 0);
    check("rd_queue_drained", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
